// File: rtl/axi_lite_slave_regfile_if.sv
// AXI4-Lite bus bundle between a master and the register-file slave.
interface axi_lite_slave_regfile_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_slave_regfile.sv
// AXI4-Lite slave holding NUM_REGS 32-bit registers with byte-strobe writes.
// Write and read paths are independent FSMs; all bus outputs are registered.
module axi_lite_slave_regfile #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 4
) (
    input logic                     aclk,
    input logic                     areset,
    axi_lite_slave_regfile_if.slave bus
);
    localparam int unsigned IdxW  = $clog2(NUM_REGS);
    localparam int unsigned StrbW = DATA_W / 8;
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;

    typedef enum logic [1:0] {WIdle, WCommit, WResp} wstate_e;
    typedef enum logic       {RIdle, RData} rstate_e;

    // Any address bit above the register window makes the access a miss.
    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:2+IdxW] == '0;
    endfunction

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    wstate_e           wstate_q, wstate_d;
    logic              aw_held_q, aw_held_d;
    logic              w_held_q, w_held_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [StrbW-1:0]  wstrb_q, wstrb_d;
    logic              awready_q, awready_d;
    logic              wready_q, wready_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;

    rstate_e           rstate_q, rstate_d;
    logic              arready_q, arready_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;

    logic [IdxW-1:0] aw_idx;
    logic [IdxW-1:0] ar_idx;
    logic            unused_addr_bits;

    assign aw_idx           = awaddr_q[2 +: IdxW];
    assign ar_idx           = bus.araddr[2 +: IdxW];
    assign unused_addr_bits = ^{awaddr_q[1:0], bus.araddr[1:0]};

    // Write path: capture AW and W independently, commit once both are held, then respond.
    always_comb begin
        wstate_d  = wstate_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        regs_d    = regs_q;
        unique case (wstate_q)
            WIdle: begin
                if (bus.awvalid && awready_q) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = bus.awaddr;
                end
                if (bus.wvalid && wready_q) begin
                    w_held_d = 1'b1;
                    wdata_d  = bus.wdata;
                    wstrb_d  = bus.wstrb;
                end
                if (aw_held_d && w_held_d) begin
                    wstate_d = WCommit;
                end
            end
            WCommit: begin
                if (in_range(awaddr_q)) begin
                    for (int i = 0; i < StrbW; i++) begin
                        if (wstrb_q[i]) begin
                            regs_d[aw_idx][8*i +: 8] = wdata_q[8*i +: 8];
                        end
                    end
                    bresp_d = RespOkay;
                end else begin
                    bresp_d = RespSlverr;
                end
                bvalid_d = 1'b1;
                wstate_d = WResp;
            end
            WResp: begin
                if (bus.bready) begin
                    bvalid_d  = 1'b0;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    wstate_d  = WIdle;
                end
            end
            default: wstate_d = WIdle;
        endcase
        // Readies follow the next state so a captured channel is never accepted twice.
        awready_d = (wstate_d == WIdle) && !aw_held_d;
        wready_d  = (wstate_d == WIdle) && !w_held_d;
    end

    // Read path: one outstanding read; data is sampled from the registers at the AR handshake.
    always_comb begin
        rstate_d = rstate_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        unique case (rstate_q)
            RIdle: begin
                if (bus.arvalid && arready_q) begin
                    if (in_range(bus.araddr)) begin
                        rdata_d = regs_q[ar_idx];
                        rresp_d = RespOkay;
                    end else begin
                        rdata_d = '0;
                        rresp_d = RespSlverr;
                    end
                    rvalid_d = 1'b1;
                    rstate_d = RData;
                end
            end
            RData: begin
                if (bus.rready) begin
                    rvalid_d = 1'b0;
                    rstate_d = RIdle;
                end
            end
            default: rstate_d = RIdle;
        endcase
        arready_d = (rstate_d == RIdle);
    end

    // State and register update; reset drops any transfer in flight.
    always_ff @(posedge aclk or negedge areset) begin
        if (!areset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            wstate_q  <= WIdle;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RespOkay;
            rstate_q  <= RIdle;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RespOkay;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            wstate_q  <= wstate_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rstate_q  <= rstate_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign bus.awready = awready_q;
    assign bus.wready  = wready_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.bresp   = bresp_q;
    assign bus.arready = arready_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;
endmodule
